// File: rtl/lfsr_prog_pkg.sv
// Shared definitions for the programmable LFSR block.
// Contents: FSM state enum, feedback mode constants and the 8-bit default tap mask.
package lfsr_prog_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        LOCK = 2'd2
    } fsm_e;

    localparam logic FIB = 1'b0;
    localparam logic GAL = 1'b1;

    // Feedback from bits 7, 5 and 3.
    localparam logic [7:0] DEFAULT_TAPS_8 = 8'hA8;

endpackage

// File: rtl/lfsr_prog_if.sv
// Configuration handshake for lfsr_prog: taps, seed and mode travel together.
// Ports (signals):
//   cfg_valid  request to reconfigure (master -> slave)
//   cfg_ready  request can be accepted this cycle (slave -> master)
//   cfg_taps   N-bit tap mask
//   cfg_seed   N-bit new register value
//   cfg_mode   0 = Fibonacci, 1 = Galois
interface lfsr_prog_if #(
    parameter int N = 8
);
    logic         cfg_valid;
    logic         cfg_ready;
    logic [N-1:0] cfg_taps;
    logic [N-1:0] cfg_seed;
    logic         cfg_mode;

    modport master (
        output cfg_valid, cfg_taps, cfg_seed, cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_taps, cfg_seed, cfg_mode,
        output cfg_ready
    );
endinterface

// File: rtl/lfsr_prog_step.sv
// One LFSR step, purely combinational.
// Ports:
//   state       current register contents
//   taps        tap mask (bit i set = state bit i feeds back)
//   mode        FIB or GAL
//   next_state  register value after one step
//   out_bit     bit shifted out by the step (MSB of state)
module lfsr_step
    import lfsr_prog_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] state,
    input  logic [N-1:0] taps,
    input  logic         mode,
    output logic [N-1:0] next_state,
    output logic         out_bit
);

    always_comb begin
        out_bit = state[N-1];
        if (mode == GAL) begin
            // Galois: the bit falling off the top is XORed into every tapped position.
            next_state = {state[N-2:0], 1'b0} ^ (state[N-1] ? taps : '0);
        end else begin
            // Fibonacci: parity of the tapped bits enters at the bottom.
            next_state = {state[N-2:0], ^(state & taps)};
        end
    end

endmodule

// File: rtl/lfsr_prog.sv
// Programmable-width LFSR with runtime taps/seed/mode, serial seed load,
// zero-state lockup detection and period measurement back to the seed.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   cfg          configuration handshake (slave side); cfg_ready = !load
//   load         serial seed load enable; s_reg_in is the bit shifted in
//   en           advance one step
//   out_valid    registered: a step happened on the previous edge
//   out_bit      registered: bit shifted out by that step
//   state        current register contents
//   lockup       register is zero and stepping is halted
//   period       step count of the last completed cycle back to the seed (0 = none found)
//   period_done  one-cycle pulse when period updates
module lfsr_prog
    import lfsr_prog_pkg::*;
#(
    parameter int           N            = 8,
    parameter logic [N-1:0] DEFAULT_TAPS = N'(DEFAULT_TAPS_8),
    parameter logic [N-1:0] DEFAULT_SEED = N'(1)
) (
    input  logic         clk,
    input  logic         reset,
    lfsr_prog_if.slave   cfg,
    input  logic         load,
    input  logic         s_reg_in,
    input  logic         en,
    output logic         out_valid,
    output logic         out_bit,
    output logic [N-1:0] state,
    output logic         lockup,
    output logic [N-1:0] period,
    output logic         period_done
);

    fsm_e         fsm_q, fsm_d;
    logic [N-1:0] state_q, state_d;
    logic [N-1:0] taps_q, taps_d;
    logic         mode_q, mode_d;
    logic [N-1:0] seed_ref_q, seed_ref_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic [N-1:0] period_q, period_d;
    logic         period_done_q, period_done_d;
    logic         out_valid_q, out_valid_d;
    logic         out_bit_q, out_bit_d;

    logic [N-1:0] step_next;
    logic         step_bit;
    logic [N-1:0] cnt_inc;
    logic         cfg_acc;

    lfsr_step #(.N(N)) u_step (
        .state      (state_q),
        .taps       (taps_q),
        .mode       (mode_q),
        .next_state (step_next),
        .out_bit    (step_bit)
    );

    // A request arriving during load is dropped, not queued.
    assign cfg.cfg_ready = !load;
    assign cfg_acc       = cfg.cfg_valid && !load;
    assign cnt_inc       = cnt_q + N'(1);

    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        taps_d        = taps_q;
        mode_d        = mode_q;
        seed_ref_d    = seed_ref_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        period_done_d = 1'b0;
        out_valid_d   = 1'b0;
        out_bit_d     = 1'b0;

        if (cfg_acc) begin
            state_d    = cfg.cfg_seed;
            taps_d     = cfg.cfg_taps;
            mode_d     = cfg.cfg_mode;
            seed_ref_d = cfg.cfg_seed;
            cnt_d      = '0;
            fsm_d      = (cfg.cfg_seed != '0) ? RUN : LOCK;
        end else if (load) begin
            state_d    = {state_q[N-2:0], s_reg_in};
            seed_ref_d = {state_q[N-2:0], s_reg_in};
            cnt_d      = '0;
            fsm_d      = LOAD;
        end else begin
            unique case (fsm_q)
                LOAD: begin
                    // The cycle that leaves LOAD does not step.
                    fsm_d = (state_q != '0) ? RUN : LOCK;
                end
                RUN: begin
                    if (state_q == '0) begin
                        fsm_d = LOCK;
                    end else if (en) begin
                        state_d     = step_next;
                        out_valid_d = 1'b1;
                        out_bit_d   = step_bit;
                        if (step_next == seed_ref_q) begin
                            period_d      = cnt_inc;
                            cnt_d         = '0;
                            period_done_d = 1'b1;
                        end else if (cnt_inc == '1) begin
                            // Seed never revisited within 2^N-1 steps: report no period.
                            period_d      = '0;
                            cnt_d         = '0;
                            period_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q         <= RUN;
            state_q       <= DEFAULT_SEED;
            taps_q        <= DEFAULT_TAPS;
            mode_q        <= FIB;
            seed_ref_q    <= DEFAULT_SEED;
            cnt_q         <= '0;
            period_q      <= '0;
            period_done_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_bit_q     <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            taps_q        <= taps_d;
            mode_q        <= mode_d;
            seed_ref_q    <= seed_ref_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            period_done_q <= period_done_d;
            out_valid_q   <= out_valid_d;
            out_bit_q     <= out_bit_d;
        end
    end

    assign state       = state_q;
    assign lockup      = (fsm_q == LOCK);
    assign period      = period_q;
    assign period_done = period_done_q;
    assign out_valid   = out_valid_q;
    assign out_bit     = out_bit_q;

endmodule

// File: tb/tb_lfsr_prog.sv
// Bench for lfsr_prog (N = 8): directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the register.
module tb_lfsr_prog;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       s_reg_in = 1'b0;
    logic       en = 1'b0;
    logic       out_valid, out_bit, lockup, period_done;
    logic [7:0] state, period;

    int n_checks = 0;
    int n_errors = 0;

    lfsr_prog_if #(.N(8)) cfg_if ();

    lfsr_prog #(.N(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg         (cfg_if),
        .load        (load),
        .s_reg_in    (s_reg_in),
        .en          (en),
        .out_valid   (out_valid),
        .out_bit     (out_bit),
        .state       (state),
        .lockup      (lockup),
        .period      (period),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    // Behavioural model
    int         m_state, m_taps, m_seed_ref, m_cnt, m_period;
    bit         m_gal, m_loading, m_locked, m_ov, m_ob, m_pd;

    function automatic int ref_next(input int s, input int t, input bit gal);
        int v;
        int fb;
        if (!gal) begin
            fb = 0;
            for (int i = 0; i < 8; i++)
                if (((s >> i) & 1) == 1 && ((t >> i) & 1) == 1) fb = fb ^ 1;
            v = (s * 2 + fb) % 256;
        end else begin
            v = (s * 2) % 256;
            if (s >= 128) v = v ^ t;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_state = 1; m_seed_ref = 1; m_taps = 'hA8; m_gal = 0;
        m_cnt = 0; m_period = 0; m_loading = 0; m_locked = 0;
        m_ov = 0; m_ob = 0; m_pd = 0;
    endtask

    task automatic model_update();
        int nxt;
        m_ov = 0; m_ob = 0; m_pd = 0;
        if (cfg_if.cfg_valid && !load) begin
            m_state = int'(cfg_if.cfg_seed); m_seed_ref = m_state;
            m_taps = int'(cfg_if.cfg_taps); m_gal = cfg_if.cfg_mode;
            m_cnt = 0; m_loading = 0; m_locked = (m_state == 0);
        end else if (load) begin
            m_state = (m_state * 2 + int'(s_reg_in)) % 256;
            m_seed_ref = m_state; m_cnt = 0; m_loading = 1; m_locked = 0;
        end else if (m_loading) begin
            m_loading = 0; m_locked = (m_state == 0);
        end else if (!m_locked) begin
            if (m_state == 0) m_locked = 1;
            else if (en) begin
                nxt = ref_next(m_state, m_taps, m_gal);
                m_ov = 1; m_ob = (m_state >= 128);
                m_cnt++;
                if (nxt == m_seed_ref) begin
                    m_period = m_cnt; m_cnt = 0; m_pd = 1;
                end else if (m_cnt == 255) begin
                    m_period = 0; m_cnt = 0; m_pd = 1;
                end
                m_state = nxt;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".state"},       32'(state),       32'(m_state));
        check({tag, ".lockup"},      32'(lockup),      32'(m_locked));
        check({tag, ".out_valid"},   32'(out_valid),   32'(m_ov));
        check({tag, ".out_bit"},     32'(out_bit),     32'(m_ob));
        check({tag, ".period"},      32'(period),      32'(m_period));
        check({tag, ".period_done"}, 32'(period_done), 32'(m_pd));
        check({tag, ".cfg_ready"},   32'(cfg_if.cfg_ready), 32'(!load));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        if (reset) model_reset();
        else model_update();
        #1;
        check_all(tag);
    endtask

    task automatic do_cfg(input logic [7:0] taps, input logic [7:0] seed, input logic mode);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_taps  = taps;
        cfg_if.cfg_seed  = seed;
        cfg_if.cfg_mode  = mode;
        cycle("cfg");
        cfg_if.cfg_valid = 1'b0;
    endtask

    logic [7:0] bits41;

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_taps  = '0;
        cfg_if.cfg_seed  = '0;
        cfg_if.cfg_mode  = 1'b0;
        model_reset();

        // Reset state
        cycle("rst");
        cycle("rst");
        check("rst_state", 32'(state), 32'h01);
        reset = 1'b0;

        // Fibonacci, default taps 0xA8, seed 0x01
        en = 1'b1;
        cycle("fib1"); check("fib1_const", 32'(state), 32'h02);
        cycle("fib2"); check("fib2_const", 32'(state), 32'h04);
        cycle("fib3"); check("fib3_const", 32'(state), 32'h08);
        cycle("fib4"); check("fib4_const", 32'(state), 32'h11);
        check("fib4_bit", 32'(out_bit), 32'h0);
        en = 1'b0;

        // Galois taps 0x1D seed 0x80, one step
        do_cfg(8'h1D, 8'h80, 1'b1);
        en = 1'b1;
        cycle("gal1");
        check("gal1_state", 32'(state), 32'h1D);
        check("gal1_obit", 32'({out_valid, out_bit}), 32'h3);
        en = 1'b0;

        // Galois taps 0x1D seed 0x01: full period of 255
        do_cfg(8'h1D, 8'h01, 1'b1);
        en = 1'b1;
        for (int i = 1; i <= 255; i++) cycle("gal_per");
        check("per_done", 32'(period_done), 32'h1);
        check("per_val", 32'(period), 32'd255);
        check("per_seed", 32'(state), 32'h01);
        cycle("per_after");
        check("per_pulse_end", 32'(period_done), 32'h0);
        en = 1'b0;

        // Serial load 1,0,1,0,0,0,0,0 with en and cfg_valid held (both ignored)
        bits41 = 8'b1010_0000;
        en = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_seed  = 8'h55;
        for (int i = 7; i >= 0; i--) begin
            load = 1'b1;
            s_reg_in = bits41[i];
            cycle("load");
            check("load_rdy", 32'(cfg_if.cfg_ready), 32'h0);
            check("load_nov", 32'(out_valid), 32'h0);
        end
        check("load_state", 32'(state), 32'hA0);
        load = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        en = 1'b0;
        cycle("load_exit");

        // Zero seed locks; load of a single 1 recovers
        do_cfg(8'hB8, 8'h00, 1'b0);
        check("lock_on", 32'(lockup), 32'h1);
        en = 1'b1;
        for (int i = 0; i < 3; i++) cycle("lock_hold");
        check("lock_frozen", 32'(state), 32'h00);
        en = 1'b0;
        load = 1'b1; s_reg_in = 1'b1;
        cycle("unlock_load");
        load = 1'b0;
        cycle("unlock_exit");
        check("unlock_lk", 32'(lockup), 32'h0);
        check("unlock_st", 32'(state), 32'h01);

        // Taps = 0 Fibonacci shifts zeros in until lockup
        do_cfg(8'h00, 8'h05, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 10; i++) cycle("taps0");
        check("taps0_lock", 32'(lockup), 32'h1);
        en = 1'b0;

        // Long runs from random configurations (periods and no-return wrap)
        for (int k = 0; k < 6; k++) begin
            do_cfg(8'($urandom), 8'($urandom_range(1, 255)), 1'($urandom));
            en = 1'b1;
            for (int i = 0; i < 300; i++) cycle("run_rand");
            en = 1'b0;
        end

        // Fully random traffic
        for (int i = 0; i < 3000; i++) begin
            cfg_if.cfg_valid = ($urandom_range(0, 99) < 4);
            cfg_if.cfg_taps  = 8'($urandom);
            cfg_if.cfg_seed  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            cfg_if.cfg_mode  = 1'($urandom);
            load             = ($urandom_range(0, 99) < 6);
            s_reg_in         = 1'($urandom);
            en               = ($urandom_range(0, 99) < 85);
            cycle("rand");
        end
        cfg_if.cfg_valid = 1'b0;

        // Asynchronous reset in the middle of a load sequence
        en = 1'b0;
        load = 1'b1; s_reg_in = 1'b1;
        for (int i = 0; i < 3; i++) cycle("preload");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst_st", 32'(state), 32'h01);
        load = 1'b0;
        cycle("rst_hold");
        reset = 1'b0;
        en = 1'b1;
        cycle("post_rst");
        check("post_rst_st", 32'(state), 32'h02);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
